serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full-adder cell
// reused over WIDTH cycles under a START/BUSY/DONE handshake.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow
// output OVF (carry into MSB xor carry out, registered at DONE).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             Co
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            OVF
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;     // partial result, filled from the MSB side
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;     // carry into the bit being processed
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             sum_bit;
   logic             cout;
   logic             accept;

   // Full-adder cell on the current LSBs plus next-state logic for all flops
   always_comb begin
      sum_bit = a_q[0] ^ b_q[0] ^ c_q;
      cout    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
      accept  = START && (state_q == ST_IDLE || state_q == ST_DONE);

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      s_d     = s_q;
      co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      case (state_q)
         ST_RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = {sum_bit, r_q[WIDTH-1:1]};
            c_d   = cout;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               // Last bit: publish result; c_q here is the carry into the MSB
               state_d = ST_DONE;
               s_d     = {sum_bit, r_q[WIDTH-1:1]};
               co_d    = cout;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = c_q ^ cout;
`endif
            end
         end
         default: begin
            // IDLE and DONE behave the same: accept a new request or rest
            if (accept) begin
               state_d = ST_RUN;
               a_d     = A;
               b_d     = B;
               r_d     = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         s_q     <= s_d;
         co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign BUSY = (state_q == ST_RUN);
   assign DONE = (state_q == ST_DONE);
   assign S    = s_q;
   assign Co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against
// an arithmetic reference ((A+B) mod 2^W, carry, signed overflow).
module tb_serial_adder;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START;
   logic [W-1:0] A, B;
   logic         BUSY, DONE, Co;
   logic [W-1:0] S;
`ifdef SERIAL_ADDER_OVF_EN
   logic         OVF;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Currently published result, as predicted by the model
   logic [W-1:0] hold_s;
   logic         hold_co;
   logic         hold_ovf;

   serial_adder #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE), .S(S), .Co(Co)
`ifdef SERIAL_ADDER_OVF_EN
      , .OVF(OVF)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: plain arithmetic on the operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] full;
      full     = {1'b0, a} + {1'b0, b};
      hold_s   = full[W-1:0];
      hold_co  = full[W];
      hold_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
   endtask

   task automatic chk_result(input string tag);
      chk({tag, "_s"}, 32'(S), 32'(hold_s));
      chk({tag, "_co"}, 32'(Co), 32'(hold_co));
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, "_ovf"}, 32'(OVF), 32'(hold_ovf));
`endif
   endtask

   task automatic chk_flags(input string tag, input logic busy, input logic done);
      chk({tag, "_busy"}, 32'(BUSY), 32'(busy));
      chk({tag, "_done"}, 32'(DONE), 32'(done));
   endtask

   // One full operation from an idle/done state; operands scrambled after accept
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      START = 1'b1; A = a; B = b;
      step();
      START = 1'b0; A = W'($urandom); B = W'($urandom);
      for (int i = 1; i <= W; i++) begin
         chk_flags(tag, 1'b1, 1'b0);
         chk_result({tag, "_hold"});
         A = W'($urandom); B = W'($urandom);
         step();
      end
      model(a, b);
      chk_flags({tag, "_dn"}, 1'b0, 1'b1);
      chk_result(tag);
      step();
      chk_flags({tag, "_idle"}, 1'b0, 1'b0);
   endtask

   initial begin
      RST = 1'b1; START = 1'b1; A = '0; B = '0;
      hold_s = '0; hold_co = 1'b0; hold_ovf = 1'b0;
      step(); step();
      // Reset wins over START
      chk_flags("rst", 1'b0, 1'b0);
      chk_result("rst");
      RST = 1'b0; START = 1'b0;
      step();
      chk_flags("rst_idle", 1'b0, 1'b0);

      // Directed cases
      run_op("d05_03", 8'h05, 8'h03);
      run_op("dff_01", 8'hFF, 8'h01);
      run_op("d80_80", 8'h80, 8'h80);
      run_op("d7f_01", 8'h7F, 8'h01);

      // START during RUN is ignored
      START = 1'b1; A = 8'h10; B = 8'h20;
      step();
      START = 1'b0;
      for (int i = 1; i <= W; i++) begin
         chk_flags("ign", 1'b1, 1'b0);
         if (i == 3) begin START = 1'b1; A = 8'hAA; B = 8'h55; end
         else        START = 1'b0;
         step();
      end
      START = 1'b0;
      model(8'h10, 8'h20);
      chk_flags("ign_dn", 1'b0, 1'b1);
      chk_result("ign");
      for (int i = 0; i < W + 2; i++) begin
         step();
         chk_flags("ign_after", 1'b0, 1'b0);
      end

      // Reset mid-RUN aborts
      START = 1'b1; A = 8'h12; B = 8'h34;
      step();
      START = 1'b0;
      for (int i = 1; i < 4; i++) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      hold_s = '0; hold_co = 1'b0; hold_ovf = 1'b0;
      chk_flags("abort", 1'b0, 1'b0);
      chk_result("abort");
      for (int i = 0; i < W + 2; i++) begin
         step();
         chk_flags("abort_quiet", 1'b0, 1'b0);
      end
      run_op("post_rst", 8'h01, 8'h01);

      // Back-to-back with START held high
      START = 1'b1; A = 8'h01; B = 8'h02;
      step();
      for (int i = 1; i <= W; i++) begin
         chk_flags("b2b1", 1'b1, 1'b0);
         A = 8'h03; B = 8'h04;
         step();
      end
      model(8'h01, 8'h02);
      chk_flags("b2b1_dn", 1'b0, 1'b1);
      chk_result("b2b1");
      step();
      START = 1'b0; A = '0; B = '0;
      for (int i = 1; i <= W; i++) begin
         chk_flags("b2b2", 1'b1, 1'b0);
         chk_result("b2b_hold");
         step();
      end
      model(8'h03, 8'h04);
      chk_flags("b2b2_dn", 1'b0, 1'b1);
      chk_result("b2b2");
      step();
      chk_flags("b2b_idle", 1'b0, 1'b0);

      // Randomized operands with random idle gaps
      for (int n = 0; n < 25; n++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) step();
         run_op("rnd", W'($urandom), W'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Structural invariant: BUSY and DONE never together
   always @(negedge CLK) begin
      if (BUSY && DONE) begin
         n_fail++;
         $display("FAIL busy_done_overlap: got 1 expected 0");
      end
   end

endmodule
